// File: rtl/cascade_hi_counter.sv
// Upper stage of a cascaded counter: counts lower-stage carries, compares
// against CMP, and raises a level interrupt that software acknowledges.
module cascade_hi_counter #(
  parameter int HI_WIDTH = 12
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESET,
  input  logic                  CIN,
  input  logic [3:0]            LO,
  input  logic                  EN,
  input  logic                  CLR,
  input  logic [HI_WIDTH-1:0]   CMP,
  input  logic                  ACK,
  output logic [HI_WIDTH-1:0]   HI,
  output logic [HI_WIDTH+3:0]   COUNT,
  output logic                  COUT,
  output logic                  MATCH,
  output logic                  IRQ,
  output logic                  OVF,
  output logic                  MISSED
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [HI_WIDTH-1:0]  hi_q, hi_d;
  logic                 match_q, match_d;
  logic                 ovf_q, ovf_d;
  logic                 missed_q, missed_d;

  logic                 inc;
  logic                 hi_all_ones;
  logic [HI_WIDTH-1:0]  hi_next;
  logic                 match_evt;

  assign inc         = EN & CIN & ~CLR;
  assign hi_all_ones = &hi_q;
  assign hi_next     = hi_q + {{(HI_WIDTH-1){1'b0}}, 1'b1};
  // A match needs a real increment; a static HI equal to a new CMP never fires.
  assign match_evt   = inc & (hi_next == CMP);

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    match_d  = 1'b0;
    ovf_d    = ovf_q;
    missed_d = missed_q;
    if (CLR) begin
      state_d  = IDLE;
      hi_d     = '0;
      ovf_d    = 1'b0;
      missed_d = 1'b0;
    end else begin
      match_d = match_evt;
      if (inc) begin
        hi_d = hi_next;
        if (hi_all_ones) ovf_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (match_evt) state_d = PENDING;
        end
        PENDING: begin
          // An acknowledge racing a new match keeps the interrupt pending.
          if (match_evt) begin
            if (!ACK) missed_d = 1'b1;
          end else if (ACK) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
      missed_q <= missed_d;
    end
  end

  assign HI     = hi_q;
  assign COUNT  = {hi_q, LO};
  assign COUT   = CIN & EN & hi_all_ones & ~CLR;
  assign MATCH  = match_q;
  assign IRQ    = (state_q == PENDING);
  assign OVF    = ovf_q;
  assign MISSED = missed_q;

endmodule

// File: tb/tb_cascade_hi_counter.sv
// Directed bench for cascade_hi_counter: an arithmetic reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_cascade_hi_counter;

  localparam int W   = 12;
  localparam int MOD = 1 << W;

  logic           CLK = 1'b0;
  logic           ASYNCRESET = 1'b1;
  logic           CIN = 1'b0;
  logic [3:0]     LO = 4'h0;
  logic           EN = 1'b0;
  logic           CLR = 1'b0;
  logic [W-1:0]   CMP = 12'h800;
  logic           ACK = 1'b0;
  logic [W-1:0]   HI;
  logic [W+3:0]   COUNT;
  logic           COUT;
  logic           MATCH;
  logic           IRQ;
  logic           OVF;
  logic           MISSED;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_hi;
  bit m_match, m_irq, m_ovf, m_missed;

  cascade_hi_counter #(.HI_WIDTH(W)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .CIN(CIN), .LO(LO), .EN(EN),
    .CLR(CLR), .CMP(CMP), .ACK(ACK), .HI(HI), .COUNT(COUNT), .COUT(COUT),
    .MATCH(MATCH), .IRQ(IRQ), .OVF(OVF), .MISSED(MISSED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: HI is an integer modulo 2^W; the interrupt is a pending bit.
  always @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      m_hi = 0; m_match = 0; m_irq = 0; m_ovf = 0; m_missed = 0;
    end else if (CLR) begin
      m_hi = 0; m_match = 0; m_irq = 0; m_ovf = 0; m_missed = 0;
    end else begin
      m_match = 0;
      if (EN && CIN) begin
        if (m_hi == MOD - 1) m_ovf = 1;
        m_hi = (m_hi + 1) % MOD;
        if (m_hi == int'(CMP)) m_match = 1;
      end
      if (m_match) begin
        if (m_irq && !ACK) m_missed = 1;
        m_irq = 1;
      end else if (ACK) begin
        m_irq = 0;
      end
    end
  end

  // Per-cycle comparison, just after each active edge.
  always @(posedge CLK) begin
    #1;
    if (!ASYNCRESET) begin
      chk("hi",     32'(HI),     32'(m_hi));
      chk("count",  32'(COUNT),  32'({m_hi[W-1:0], LO}));
      chk("cout",   32'(COUT),   32'(CIN && EN && !CLR && m_hi == MOD - 1));
      chk("match",  32'(MATCH),  32'(m_match));
      chk("irq",    32'(IRQ),    32'(m_irq));
      chk("ovf",    32'(OVF),    32'(m_ovf));
      chk("missed", 32'(MISSED), 32'(m_missed));
    end
  end

  task automatic step(input logic cin, input logic en, input logic clr, input logic ack);
    CIN = cin; EN = en; CLR = clr; ACK = ack;
    @(negedge CLK);
  endtask

  task automatic run_cin(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_hi",  32'(HI),  32'd0);
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_match", 32'(MATCH), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    @(negedge CLK);
    ASYNCRESET = 1'b0;

    // Free-run: LO wraps every 16 cycles and carries into HI.
    for (int i = 0; i < 512; i++) begin
      LO = 4'(i);
      CIN = (LO == 4'hF);
      EN = 1'b1;
      @(negedge CLK);
    end
    CIN = 1'b0; LO = 4'h7;
    #1;
    chk("free_hi",    32'(HI),    32'd32);
    chk("free_count", 32'(COUNT), 32'h0207);

    // Match on CMP=3; ACK while idle is ignored.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    CMP = 12'd3;
    step(1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("idle_ack_irq", 32'(IRQ), 32'd0);
    for (int p = 0; p < 3; p++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (p < 2) begin
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    #1;
    chk("m3_match", 32'(MATCH), 32'd1);
    chk("m3_irq",   32'(IRQ),   32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("m3_match_off", 32'(MATCH), 32'd0);
    chk("m3_irq_hold",  32'(IRQ),   32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("m3_ack_irq", 32'(IRQ), 32'd0);

    // ACK and match on the same edge: stays pending, no miss.
    CMP = 12'd4;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    CMP = 12'd5;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    chk("race_irq",    32'(IRQ),    32'd1);
    chk("race_missed", 32'(MISSED), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("race_ack_irq", 32'(IRQ), 32'd0);

    // Missed: CMP=1, no ACK, full wrap back to 1.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    CMP = 12'd1;
    run_cin(1);
    #1 chk("miss_irq0", 32'(IRQ), 32'd1);
    run_cin(MOD);
    #1;
    chk("miss_hi",     32'(HI),     32'd1);
    chk("miss_missed", 32'(MISSED), 32'd1);
    chk("miss_irq",    32'(IRQ),    32'd1);
    chk("miss_ovf",    32'(OVF),    32'd1);

    // Wrap: count to all ones, then carry out and overflow.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    CMP = 12'h555;
    run_cin(MOD - 1);
    CIN = 1'b1;
    #1;
    chk("wrap_hi",   32'(HI),   32'hFFF);
    chk("wrap_cout", 32'(COUT), 32'd1);
    @(negedge CLK);
    #1;
    chk("wrap_hi0", 32'(HI),  32'd0);
    chk("wrap_ovf", 32'(OVF), 32'd1);

    // Priority: CLR beats an increment that would hit CMP.
    CMP = 12'd5;
    run_cin(4);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("prio_hi",    32'(HI),    32'd0);
    chk("prio_match", 32'(MATCH), 32'd0);
    chk("prio_irq",   32'(IRQ),   32'd0);
    chk("prio_ovf",   32'(OVF),   32'd0);

    // Async reset between edges while pending at HI=5.
    run_cin(5);
    CIN = 1'b0;
    #1;
    chk("ar_pre_hi",  32'(HI),  32'd5);
    chk("ar_pre_irq", 32'(IRQ), 32'd1);
    #1 ASYNCRESET = 1'b1;
    #1;
    chk("ar_hi",  32'(HI),  32'd0);
    chk("ar_irq", 32'(IRQ), 32'd0);
    @(negedge CLK);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("ar_hold_hi", 32'(HI), 32'd0);
    ASYNCRESET = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk("ar_post_hi", 32'(HI), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
